// File: rtl/uart_fifo_core.sv
`timescale 1ns/1ps
// uart_fifo_core: single-clock UART with oversample tick generator, TX FIFO
// with ready/valid input, 1/2 stop bits and majority-vote RX sampling.
module uart_fifo_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int DIV_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DIV_WIDTH-1:0]      Baud_Div,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      stop_bits,
    input  logic [DATA_WIDTH-1:0]     TX_IN_P,
    input  logic                      TX_IN_V,
    output logic                      TX_IN_RDY,
    output logic                      TX_OUT_S,
    output logic                      TX_BUSY,
    input  logic                      RX_IN_S,
    output logic [DATA_WIDTH-1:0]     RX_OUT_P,
    output logic                      RX_OUT_V,
    output logic                      parity_error,
    output logic                      framing_error,
    output logic [2:0]                tx_state,
    output logic [2:0]                rx_state
);

    localparam int PW = PRESCALE_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t tx_st, rx_st;

    assign tx_state = tx_st;
    assign rx_state = rx_st;

    // ---------------- oversample tick generator ----------------
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    // >= rather than == so a Baud_Div lowered while idle cannot strand the
    // counter above the new terminal value.
    assign tick = (div_cnt >= Baud_Div);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // ---------------- per-bit sample positions ----------------
    logic [PW-1:0] pre_last, samp_a, samp_b, samp_c;

    assign pre_last = Prescale - PW'(1);
    assign samp_b   = Prescale >> 1;
    assign samp_a   = samp_b - PW'(1);
    assign samp_c   = samp_b + PW'(1);

    // ---------------- TX FIFO ----------------
    // Handshake: a word transfers on every rising CLK edge where TX_IN_V and
    // TX_IN_RDY are both high; TX_IN_P is only looked at on those edges and
    // TX_IN_RDY never depends combinationally on TX_IN_V.
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_next;
    logic                  push, pop, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign push       = TX_IN_V & TX_IN_RDY;
    assign fifo_empty = (count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            TX_IN_RDY <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            TX_IN_RDY <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= TX_IN_P;
    end

    // ---------------- TX FSM ----------------
    logic [PW-1:0]         tx_tcnt;
    logic [IW-1:0]         tx_idx;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par;
    logic                  tx_stop_idx;
    logic                  tx_bit_end;
    logic                  tx_last_stop_end;

    assign tx_bit_end       = tick && (tx_tcnt == pre_last);
    assign tx_last_stop_end = (tx_st == STOP) && tx_bit_end && (tx_stop_idx == stop_bits);

    // Popping at the end of the last stop bit chains frames with no idle gap.
    assign pop = tick && !fifo_empty && ((tx_st == IDLE) || tx_last_stop_end);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_st       <= IDLE;
            tx_tcnt     <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_stop_idx <= 1'b0;
            TX_OUT_S    <= 1'b1;
            TX_BUSY     <= 1'b0;
        end else begin
            if (tick && tx_st != IDLE) begin
                tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + PW'(1);
            end
            case (tx_st)
                IDLE: begin
                    if (pop) begin
                        tx_st    <= START;
                        tx_tcnt  <= '0;
                        tx_shift <= fifo_head;
                        tx_par   <= (^fifo_head) ^ parity_type;
                        TX_OUT_S <= 1'b0;
                        TX_BUSY  <= 1'b1;
                    end
                end
                START: begin
                    if (tx_bit_end) begin
                        tx_st    <= DATA;
                        tx_idx   <= '0;
                        TX_OUT_S <= tx_shift[0];
                    end
                end
                DATA: begin
                    if (tx_bit_end) begin
                        if (tx_idx == IW'(DATA_WIDTH - 1)) begin
                            if (parity_enable) begin
                                tx_st    <= PARITY;
                                TX_OUT_S <= tx_par;
                            end else begin
                                tx_st       <= STOP;
                                tx_stop_idx <= 1'b0;
                                TX_OUT_S    <= 1'b1;
                            end
                        end else begin
                            tx_idx   <= tx_idx + IW'(1);
                            tx_shift <= tx_shift >> 1;
                            TX_OUT_S <= tx_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tx_bit_end) begin
                        tx_st       <= STOP;
                        tx_stop_idx <= 1'b0;
                        TX_OUT_S    <= 1'b1;
                    end
                end
                STOP: begin
                    if (tx_bit_end) begin
                        if (tx_stop_idx != stop_bits) begin
                            tx_stop_idx <= 1'b1;
                        end else if (pop) begin
                            tx_st    <= START;
                            tx_tcnt  <= '0;
                            tx_shift <= fifo_head;
                            tx_par   <= (^fifo_head) ^ parity_type;
                            TX_OUT_S <= 1'b0;
                        end else begin
                            tx_st   <= IDLE;
                            TX_BUSY <= 1'b0;
                        end
                    end
                end
                default: begin
                    tx_st    <= IDLE;
                    TX_OUT_S <= 1'b1;
                    TX_BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic                  rx_s1, rx_s2;
    logic [PW-1:0]         rx_tcnt;
    logic [IW-1:0]         rx_idx;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [1:0]            rx_samp;
    logic                  rx_perr, rx_ferr, rx_stop_idx;
    logic                  rx_active, rx_bit_end, rx_at_a, rx_at_b, rx_at_c;
    logic                  rx_maj, rx_stop_bad;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RX_IN_S;
            rx_s2 <= rx_s1;
        end
    end

    assign rx_active  = (rx_st != IDLE);
    assign rx_bit_end = rx_active && tick && (rx_tcnt == pre_last);
    assign rx_at_a    = rx_active && tick && (rx_tcnt == samp_a);
    assign rx_at_b    = rx_active && tick && (rx_tcnt == samp_b);
    assign rx_at_c    = rx_active && tick && (rx_tcnt == samp_c);

    // Third sample is taken live at samp_c and voted with the two stored ones.
    assign rx_maj      = (rx_samp[1] & rx_samp[0]) | (rx_samp[1] & rx_s2) | (rx_samp[0] & rx_s2);
    assign rx_stop_bad = rx_ferr | ~rx_maj;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_st         <= IDLE;
            rx_tcnt       <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_samp       <= 2'b11;
            rx_perr       <= 1'b0;
            rx_ferr       <= 1'b0;
            rx_stop_idx   <= 1'b0;
            RX_OUT_P      <= '0;
            RX_OUT_V      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            RX_OUT_V      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            if (rx_active && tick) begin
                rx_tcnt <= rx_bit_end ? '0 : rx_tcnt + PW'(1);
            end
            if (rx_at_a) rx_samp[1] <= rx_s2;
            if (rx_at_b) rx_samp[0] <= rx_s2;
            case (rx_st)
                IDLE: begin
                    if (!rx_s2) begin
                        rx_st       <= START;
                        rx_tcnt     <= '0;
                        rx_perr     <= 1'b0;
                        rx_ferr     <= 1'b0;
                        rx_stop_idx <= 1'b0;
                    end
                end
                START: begin
                    if (rx_at_c && rx_maj) begin
                        rx_st <= IDLE;
                    end else if (rx_bit_end) begin
                        rx_st  <= DATA;
                        rx_idx <= '0;
                    end
                end
                DATA: begin
                    if (rx_at_c) rx_shift <= {rx_maj, rx_shift[DATA_WIDTH-1:1]};
                    if (rx_bit_end) begin
                        if (rx_idx == IW'(DATA_WIDTH - 1)) begin
                            rx_st <= parity_enable ? PARITY : STOP;
                        end else begin
                            rx_idx <= rx_idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (rx_at_c) rx_perr <= rx_maj ^ (^rx_shift) ^ parity_type;
                    if (rx_bit_end) rx_st <= STOP;
                end
                STOP: begin
                    if (rx_at_c) begin
                        if (rx_stop_idx == stop_bits) begin
                            // Leave half a bit early so the next start edge is seen.
                            rx_st         <= IDLE;
                            parity_error  <= rx_perr;
                            framing_error <= rx_stop_bad;
                            if (!rx_perr && !rx_stop_bad) begin
                                RX_OUT_P <= rx_shift;
                                RX_OUT_V <= 1'b1;
                            end
                        end else begin
                            rx_ferr <= rx_stop_bad;
                        end
                    end else if (rx_bit_end) begin
                        rx_stop_idx <= 1'b1;
                    end
                end
                default: rx_st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
`timescale 1ns/1ps
// Bench for uart_fifo_core: table of loopback frames plus hand-written
// sequences for FIFO back-pressure, RX errors, glitches and mid-frame reset.
module tb_uart_fifo_core;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] baud;
  logic [PW-1:0] pre;
  logic          pen, ptype, stop2;
  logic [DW-1:0] tx_p;
  logic          tx_v, tx_rdy, tx_out, tx_busy;
  logic          rx_line, rx_drv, loop_en;
  logic [DW-1:0] rx_out_p;
  logic          rx_out_v, perr, ferr;
  logic [2:0]    tx_state, rx_state;

  assign rx_line = loop_en ? tx_out : rx_drv;

  uart_fifo_core #(
    .DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .DIV_WIDTH(BW), .FIFO_DEPTH(FD)
  ) dut (
    .CLK(clk), .RST(rst), .Baud_Div(baud), .Prescale(pre),
    .parity_enable(pen), .parity_type(ptype), .stop_bits(stop2),
    .TX_IN_P(tx_p), .TX_IN_V(tx_v), .TX_IN_RDY(tx_rdy),
    .TX_OUT_S(tx_out), .TX_BUSY(tx_busy), .RX_IN_S(rx_line),
    .RX_OUT_P(rx_out_p), .RX_OUT_V(rx_out_v),
    .parity_error(perr), .framing_error(ferr),
    .tx_state(tx_state), .rx_state(rx_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int got_rd = 0;
  int rx_v_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  int n_vec = 0, n_bad = 0;
  logic line_bits [0:2047];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_out_v) begin
        rx_v_cnt++;
        got_q.push_back(rx_out_p);
      end
      if (perr) perr_cnt++;
      if (ferr) ferr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    logic [DW-1:0] e;
    while ((got_q.size() - got_rd) < exp_q.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_count"}, got_q.size() - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      check(name, got_q[got_rd], e);
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [DW-1:0] d);
    @(negedge clk);
    tx_v = 1'b1;
    tx_p = d;
    @(posedge clk);
    #1;
    tx_v = 1'b0;
  endtask

  task automatic record_frame(output int nbusy);
    int guard = 0;
    nbusy = 0;
    while (!tx_busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("busy_rise", tx_busy, 1);
    while (tx_busy && nbusy < 2048) begin
      line_bits[nbusy] = tx_out;
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic drive_bit(input logic v, input int bitlen);
    rx_drv = v;
    repeat (bitlen) @(negedge clk);
  endtask

  task automatic send_raw(input logic [DW-1:0] d, input int bitlen, input bit use_par,
                          input bit odd, input bit flip, input bit stop_v);
    drive_bit(1'b0, bitlen);
    for (int i = 0; i < DW; i++) drive_bit(d[i], bitlen);
    if (use_par) drive_bit((^d) ^ odd ^ flip, bitlen);
    drive_bit(stop_v, bitlen);
    drive_bit(1'b1, 3 * bitlen);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    int         div;
    int         pres;
    bit         par_en;
    bit         par_odd;
    bit         two_stop;
    int         exp_start;
    int         exp_busy;
    bit         exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic apply_vec(input vec_t v, input int idx);
    int nbusy, zeros, bitlen;
    logic [DW-1:0] recon;
    string tag;
    tag = $sformatf("v%0d", idx);
    baud   = BW'(v.div);
    pre    = PW'(v.pres);
    pen    = v.par_en;
    ptype  = v.par_odd;
    stop2  = v.two_stop;
    bitlen = v.pres * (v.div + 1);
    send_word(v.data);
    exp_q.push_back(v.data);
    record_frame(nbusy);
    check({tag, "_busy_len"}, nbusy, v.exp_busy);
    zeros = 0;
    for (int i = 0; i < v.exp_start; i++) if (line_bits[i] == 1'b0) zeros++;
    check({tag, "_start_low"}, zeros, v.exp_start);
    for (int k = 0; k < DW; k++) recon[k] = line_bits[bitlen * (1 + k) + bitlen / 2];
    check({tag, "_line_data"}, recon, v.data);
    if (v.par_en) check({tag, "_parity_bit"}, line_bits[bitlen * (1 + DW) + bitlen / 2], v.exp_par);
    check({tag, "_stop_level"}, line_bits[nbusy - 1], 1);
    drain({tag, "_rx_data"});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] fifo_words [6];
    int   accepted, nbusy, guard, v0, p0, f0;
    logic last_rdy;

    rst = 1'b1; baud = '0; pre = PW'(8); pen = 1'b0; ptype = 1'b0; stop2 = 1'b0;
    tx_p = '0; tx_v = 1'b0; rx_drv = 1'b1; loop_en = 1'b1;

    vecs[0] = '{8'hA5, 0, 8,  1'b0, 1'b0, 1'b0, 8,  80,  1'b0};
    vecs[1] = '{8'h3C, 3, 16, 1'b1, 1'b1, 1'b1, 64, 768, 1'b1};
    vecs[2] = '{8'h01, 1, 8,  1'b1, 1'b0, 1'b0, 16, 176, 1'b1};
    vecs[3] = '{8'h7E, 0, 10, 1'b1, 1'b0, 1'b1, 10, 120, 1'b0};
    vecs[4] = '{8'h00, 2, 8,  1'b0, 1'b0, 1'b1, 24, 264, 1'b0};
    vecs[5] = '{8'hC8, 0, 12, 1'b1, 1'b1, 1'b0, 12, 132, 1'b0};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_rdy", tx_rdy, 1);
    check("rst_rx_out_p", rx_out_p, 0);
    check("rst_rx_out_v", rx_out_v, 0);
    check("rst_perr", perr, 0);
    check("rst_ferr", ferr, 0);
    check("rst_tx_state", tx_state, 0);
    check("rst_rx_state", rx_state, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_rdy", tx_rdy, 1);

    // loopback table
    for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

    // FIFO back-pressure: 8N1, Baud_Div 0, Prescale 8
    baud = '0; pre = PW'(8); pen = 1'b0; ptype = 1'b0; stop2 = 1'b0;
    fifo_words[0] = 8'h11; fifo_words[1] = 8'h22; fifo_words[2] = 8'h33;
    fifo_words[3] = 8'h44; fifo_words[4] = 8'h55; fifo_words[5] = 8'h66;
    accepted = 0; nbusy = 0; last_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_busy) nbusy++;
      last_rdy = tx_rdy;
      tx_v = 1'b1;
      tx_p = fifo_words[i];
      if (tx_rdy) begin
        accepted++;
        exp_q.push_back(fifo_words[i]);
      end
    end
    @(negedge clk);
    tx_v = 1'b0;
    if (tx_busy) nbusy++;
    check("fifo_accepts", accepted, 5);
    check("fifo_rdy_when_full", last_rdy, 0);
    guard = 0;
    while (guard < 3000) begin
      @(negedge clk);
      guard++;
      if (tx_busy) nbusy++;
      else break;
    end
    check("fifo_busy_len", nbusy, 400);
    drain("fifo_order");
    check("fifo_rdy_after", tx_rdy, 1);

    // RX errors: driven line, 8E1, Baud_Div 0, Prescale 8
    loop_en = 1'b0; pen = 1'b1; ptype = 1'b0; stop2 = 1'b0;
    repeat (8) @(negedge clk);
    send_raw(8'h96, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h96);
    drain("rx_good");

    v0 = rx_v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_raw(8'h33, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", rx_v_cnt - v0, 0);
    check("ferr_no_perr", perr_cnt - p0, 0);
    check("ferr_hold_data", rx_out_p, 8'h96);

    v0 = rx_v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_raw(8'h33, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    check("perr_pulse", perr_cnt - p0, 1);
    check("perr_no_valid", rx_v_cnt - v0, 0);
    check("perr_no_ferr", ferr_cnt - f0, 0);
    check("perr_hold_data", rx_out_p, 8'h96);

    v0 = rx_v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_raw(8'hE1, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    check("both_perr", perr_cnt - p0, 1);
    check("both_ferr", ferr_cnt - f0, 1);
    check("both_no_valid", rx_v_cnt - v0, 0);

    // glitch rejection: low for Prescale/2-2 ticks, then a valid frame
    pen = 1'b0;
    v0 = rx_v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
    check("glitch_no_valid", rx_v_cnt - v0, 0);
    check("glitch_no_perr", perr_cnt - p0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_rx_idle", rx_state, 0);
    send_raw(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h5A);
    drain("glitch_follow");

    // reset in the middle of a TX start bit
    loop_en = 1'b1;
    send_word(8'hC3);
    guard = 0;
    while (!tx_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("mid_frame_line_low", tx_out, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_tx_out", tx_out, 1);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_rdy", tx_rdy, 1);
    check("rst_mid_rx_out_p", rx_out_p, 0);
    check("rst_mid_tx_state", tx_state, 0);
    v0 = rx_v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_mid_no_valid", rx_v_cnt - v0, 0);
    check("rst_mid_no_err", (perr_cnt - p0) + (ferr_cnt - f0), 0);
    check("rst_mid_rdy_after", tx_rdy, 1);
    check("rst_mid_line_idle", tx_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
